mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake and returns one response after a fixed, configurable latency. It performs byte, halfword and word accesses selected by the RISC-V func3 encoding, with load sign/zero extension done inside the block. It replaces the zero-latency data memory when the multi-cycle core variant is integrated.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words of storage; word index = req_addr[31:2]
LATENCY, 2, cycles from request acceptance to response; legal range 1..15

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; the low byte or halfword is used for sub-word stores
req_size  input  3  func3 code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  output  1  request rejected (misaligned, out of range, illegal size); valid with rsp_valid

Behaviour:
- Storage is little-endian; byte k of word w is at address 4w+k.
- Storage contents are not reset.
- Reset: state = IDLE, req_ready = 0 while rst = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - If req_valid = 1, the request is accepted at the clock edge: capture we, addr, wdata and size.
  - Next state is RESP if LATENCY = 1; otherwise BUSY, with counter = LATENCY-2.
- BUSY:
  - req_ready = 0.
  - Counter decrements each cycle; when the counter is 0, go to RESP.
- RESP:
  - req_ready = 0. rsp_valid = 1 for exactly one cycle.
  - Next state is IDLE.
- Timing: a request accepted at edge E produces rsp_valid in the cycle following edge E+LATENCY-1, i.e. LATENCY cycles after the acceptance cycle. The next request can be accepted at the earliest LATENCY+1 cycles after the previous acceptance.
- Only one request is ever outstanding. Any req_valid while not in IDLE is ignored and not queued; the initiator holds req_valid until it sees req_ready.
- Error checks are evaluated on the captured request:
  - misaligned: halfword access with addr[0] = 1, or word access with addr[1:0] != 0
  - out of range: addr[31:2] >= DEPTH_WORDS
  - illegal size: 011, 110 or 111, or a store with size 100 or 101
  - On any error: rsp_err = 1, rsp_rdata = 0, storage unchanged.
- Stores:
  - Storage is written on the clock edge that ends the RESP cycle; only the addressed byte lanes change.
  - rsp_rdata = 0.
- Loads:
  - Data is read from storage in the RESP cycle. Because the block accepts one request at a time, a load always sees all earlier stores.
  - LB/LH sign-extend the selected byte or halfword; LBU/LHU zero-extend it; LW returns the whole word.
  - The byte lane is selected by addr[1:0]; the halfword lane is selected by addr[1].
- rsp_rdata and rsp_err are held at 0 in every cycle where rsp_valid = 0.
- Reset in BUSY or RESP aborts the request: no storage write, no response, and the state returns to IDLE after rst deasserts.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10, LATENCY=2 -> rsp_valid exactly 2 cycles after each acceptance; LW returns 0xDEADBEEF with rsp_err = 0; req_ready = 0 during the BUSY and RESP cycles.
- After the SW above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF; then SH 0x1234 to 0x12, then LW 0x10 -> 0x123455EF.
- LW 0x11, SH 0x13, address 4*DEPTH_WORDS, size 011 -> each returns rsp_err = 1 and rsp_rdata = 0; a following LW 0x10 shows storage unchanged.
- LATENCY=1 with req_valid held high continuously -> accepts every 2nd cycle and rsp_valid follows each acceptance by 1 cycle; no request is dropped or duplicated.
- Issue SW 0xA5A5A5A5 to 0x20 and assert rst during BUSY -> no rsp_valid; after reset, LW 0x20 returns the prior contents.

Source files
------------

// File: rtl/mem_responder.sv
// Single-outstanding memory responder for the load/store port with a fixed response latency.
// Performs RISC-V byte/halfword/word accesses; loads are sign- or zero-extended here.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;

  logic            accept;
  logic            in_range;
  logic            illegal;
  logic            misaligned;
  logic            err;
  logic [IdxW-1:0] idx;
  logic [31:0]     rd_word;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;
  logic            wr_en;
  logic [3:0]      be;
  logic [31:0]     st_data;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = ~rst;
        if (req_valid) begin
          if (LATENCY <= 1) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = 4'(LATENCY - 2);
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accept = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      size_q  <= req_size;
    end
  end

  // Error checks operate on the captured request, not the live request bus.
  always_comb begin
    in_range   = {2'b00, addr_q[31:2]} < DEPTH_WORDS;
    illegal    = (size_q == 3'b011) || (size_q == 3'b110) || (size_q == 3'b111) ||
                 (we_q && size_q[2]);
    misaligned = ((size_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((size_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    err        = illegal | misaligned | ~in_range;
  end

  assign idx     = addr_q[IdxW+1:2];
  assign rd_word = in_range ? mem[idx] : 32'd0;
  assign ld_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = 32'd0;
    case (size_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  // Gating with rst makes a reset during RESP abort the response and the store.
  assign rsp_valid = (state_q == StResp) & ~rst;
  assign rsp_err   = rsp_valid & err;
  assign rsp_rdata = (rsp_valid && !err && !we_q) ? ld_data : 32'd0;

  always_comb begin
    be      = 4'b0000;
    st_data = wdata_q;
    case (size_q[1:0])
      2'b00: begin
        be      = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign wr_en = rsp_valid & we_q & ~err;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem[idx][8*k +: 8] <= st_data[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table on a LATENCY=2 instance plus a randomized
// back-to-back run on a LATENCY=1 instance checked against a byte-array memory model.
module tb_mem_responder;

  localparam int unsigned Lat   = 2;
  localparam int unsigned Depth = 1024;
  localparam int unsigned Depth1 = 64;
  localparam int NInit = 64;
  localparam int NOps  = NInit + 150;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0]  req_size;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [2:0]  b_req_size;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.DEPTH_WORDS(Depth), .LATENCY(Lat)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(Depth1), .LATENCY(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_size  (b_req_size),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  // Byte-addressed model of the LATENCY=1 instance's storage.
  logic [7:0] mdl [256];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_op(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [2:0] size,
                                   output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] v;
    n   = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    rd  = 32'd0;
    err = (size == 3'd3) || (size == 3'd6) || (size == 3'd7) || (we && size >= 3'd4) ||
          ((addr % n) != 0) || ((addr / 4) >= Depth1);
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mdl[addr + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(mdl[addr + i]) << (8 * i));
      if (size < 3'd4 && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      rd = v;
    end
  endfunction

  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        output logic [31:0] rd, output logic er);
    int k;
    int w;
    rd = 32'd0;
    er = 1'b0;
    w  = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_ready"}, 32'(req_ready), 32'd1);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_valid = 1'b1;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) begin
        k  = c;
        rd = rsp_rdata;
        er = rsp_err;
        break;
      end
      check({name, "_busy_ready"}, 32'(req_ready), 32'd0);
      check({name, "_quiet"}, rsp_rdata | 32'(rsp_err), 32'd0);
    end
    check({name, "_latency"}, 32'(k), 32'(Lat));
    check({name, "_resp_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    check({name, "_strobe"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        op_we   [NOps];
    logic [31:0] op_addr [NOps];
    logic [31:0] op_wdata[NOps];
    logic [2:0]  op_size [NOps];
    int cyc, last_acc, idx, nrsp;
    exp_t e;
    logic [31:0] m_rd;
    logic        m_er;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_size = '0;

    tbl.push_back('{"sw10",     1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
    tbl.push_back('{"lw10",     1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{"lb13",     1'b0, 32'h13,   32'h0,        3'b000, 32'hFFFFFFDE, 1'b0});
    tbl.push_back('{"lbu13",    1'b0, 32'h13,   32'h0,        3'b100, 32'h000000DE, 1'b0});
    tbl.push_back('{"lh10",     1'b0, 32'h10,   32'h0,        3'b001, 32'hFFFFBEEF, 1'b0});
    tbl.push_back('{"lhu12",    1'b0, 32'h12,   32'h0,        3'b101, 32'h0000DEAD, 1'b0});
    tbl.push_back('{"sb11",     1'b1, 32'h11,   32'hAABBCC55, 3'b000, 32'h0,        1'b0});
    tbl.push_back('{"lw10_sb",  1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0});
    tbl.push_back('{"sh12",     1'b1, 32'h12,   32'hFFFF1234, 3'b001, 32'h0,        1'b0});
    tbl.push_back('{"lw10_sh",  1'b0, 32'h10,   32'h0,        3'b010, 32'h123455EF, 1'b0});
    tbl.push_back('{"lw11_mis", 1'b0, 32'h11,   32'h0,        3'b010, 32'h0,        1'b1});
    tbl.push_back('{"sh13_mis", 1'b1, 32'h13,   32'hFFFFFFFF, 3'b001, 32'h0,        1'b1});
    tbl.push_back('{"lw_oor",   1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1});
    tbl.push_back('{"size011",  1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1});
    tbl.push_back('{"sbu_ill",  1'b1, 32'h10,   32'h0,        3'b100, 32'h0,        1'b1});
    tbl.push_back('{"sw110",    1'b1, 32'h10,   32'h0,        3'b110, 32'h0,        1'b1});
    tbl.push_back('{"lw10_kept",1'b0, 32'h10,   32'h0,        3'b010, 32'h123455EF, 1'b0});
    tbl.push_back('{"lb12",     1'b0, 32'h12,   32'h0,        3'b000, 32'h00000034, 1'b0});
    tbl.push_back('{"lh12",     1'b0, 32'h12,   32'h0,        3'b001, 32'h00001234, 1'b0});
    tbl.push_back('{"lbu10",    1'b0, 32'h10,   32'h0,        3'b100, 32'h000000EF, 1'b0});
    tbl.push_back('{"sw20",     1'b1, 32'h20,   32'h01020304, 3'b010, 32'h0,        1'b0});

    repeat (3) @(negedge clk);
    check("rst_ready",  32'(req_ready), 32'd0);
    check("rst_valid",  32'(rsp_valid), 32'd0);
    check("rst_rdata",  rsp_rdata,      32'd0);
    check("rst_err",    32'(rsp_err),   32'd0);
    check("rst_ready1", 32'(b_req_ready), 32'd0);
    check("rst_valid1", 32'(b_rsp_valid), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      do_req(tbl[i].name, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size, rd, er);
      check({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rdata);
      check({tbl[i].name, "_err"}, 32'(er), 32'(tbl[i].exp_err));
    end

    // Reset while BUSY must abort the store and suppress the response.
    @(negedge clk);
    check("abort_idle", 32'(req_ready), 32'd1);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_size = 3'b010;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_accepted", 32'(req_ready), 32'd0);
    rst = 1'b1;
    check("abort_no_rsp0", 32'(rsp_valid), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_no_rsp1", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_rsp2", 32'(rsp_valid), 32'd0);
    end
    check("abort_ready", 32'(req_ready), 32'd1);
    do_req("lw20_after_abort", 1'b0, 32'h20, 32'h0, 3'b010, rd, er);
    check("lw20_rdata", rd, 32'h01020304);
    check("lw20_err", 32'(er), 32'd0);

    // LATENCY=1 instance: fill storage, then random ops with req_valid held high.
    for (int i = 0; i < NOps; i++) begin
      if (i < NInit) begin
        op_we[i] = 1'b1; op_addr[i] = 32'(4 * i); op_wdata[i] = $urandom; op_size[i] = 3'b010;
      end else begin
        op_we[i]    = 1'($urandom_range(0, 1));
        op_size[i]  = 3'($urandom_range(0, 7));
        op_wdata[i] = $urandom;
        op_addr[i]  = ($urandom_range(0, 9) == 0) ? 32'(32'h100 + $urandom_range(0, 255))
                                                   : 32'($urandom_range(0, 255));
      end
    end

    cyc = 0; last_acc = -1; idx = 0; nrsp = 0;
    for (int c = 0; c < 3000 && nrsp < NOps; c++) begin
      @(negedge clk);
      cyc++;
      if (b_rsp_valid) begin
        check("l1_rsp_lat", 32'(cyc - last_acc), 32'd1);
        if (exp_q.size() == 0) begin
          check("l1_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("l1_rdata", b_rsp_rdata, e.rdata);
          check("l1_err", 32'(b_rsp_err), 32'(e.err));
        end
        nrsp++;
      end else begin
        check("l1_quiet", b_rsp_rdata | 32'(b_rsp_err), 32'd0);
      end
      if (idx < NOps) begin
        b_req_we = op_we[idx]; b_req_addr = op_addr[idx];
        b_req_wdata = op_wdata[idx]; b_req_size = op_size[idx];
        b_req_valid = 1'b1;
      end else begin
        b_req_valid = 1'b0;
      end
      if (b_req_ready && idx < NOps) begin
        if (last_acc >= 0) check("l1_accept_gap", 32'(cyc - last_acc), 32'd2);
        model_op(op_we[idx], op_addr[idx], op_wdata[idx], op_size[idx], m_rd, m_er);
        exp_q.push_back('{m_rd, m_er});
        last_acc = cyc;
        idx++;
      end
    end
    b_req_valid = 1'b0;
    check("l1_all_accepted", 32'(idx), 32'(NOps));
    check("l1_all_responded", 32'(nrsp), 32'(NOps));
    check("l1_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
